// File: rtl/muldiv_pkg.sv
// rtl/muldiv_pkg.sv - shared op encodings and FSM state type for the multiply/divide unit
package muldiv_pkg;

  // Matches the decoder's extended ALUControl encodings
  localparam logic [2:0] OP_MUL  = 3'b100;
  localparam logic [2:0] OP_SMUL = 3'b101;
  localparam logic [2:0] OP_UMUL = 3'b110;
  localparam logic [2:0] OP_DIV  = 3'b111;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CALC = 2'd1,
    S_FIX  = 2'd2,
    S_DONE = 2'd3
  } muldiv_state_t;

endpackage

// File: rtl/muldiv_step.sv
// rtl/muldiv_step.sv - one combinational iteration: shift-add multiply or restoring divide
module muldiv_step #(
  parameter int WIDTH = 32
) (
  input  logic             is_div,
  input  logic [WIDTH-1:0] hi_in,
  input  logic [WIDTH-1:0] lo_in,
  input  logic [WIDTH-1:0] m,
  output logic [WIDTH-1:0] hi_out,
  output logic [WIDTH-1:0] lo_out
);

  logic [WIDTH:0]   sum;
  logic [WIDTH:0]   shifted;
  logic [WIDTH+1:0] diff;

  always_comb begin
    sum     = {1'b0, hi_in} + (lo_in[0] ? {1'b0, m} : '0);
    shifted = {hi_in, lo_in[WIDTH-1]};
    diff    = {1'b0, shifted} - {2'b00, m};
    hi_out  = '0;
    lo_out  = '0;
    if (is_div) begin
      // Borrow out of the trial subtract means restore the shifted remainder
      if (!diff[WIDTH+1]) begin
        hi_out = diff[WIDTH-1:0];
        lo_out = {lo_in[WIDTH-2:0], 1'b1};
      end else begin
        hi_out = shifted[WIDTH-1:0];
        lo_out = {lo_in[WIDTH-2:0], 1'b0};
      end
    end else begin
      // Product accumulates in {hi, lo}; multiplier bits drain out of lo
      hi_out = sum[WIDTH:1];
      lo_out = {sum[0], lo_in[WIDTH-1:1]};
    end
  end

endmodule

// File: rtl/muldiv_unit.sv
// rtl/muldiv_unit.sv - iterative multiply/divide unit: FSM, counter, operand/accumulator registers, sign fix
import muldiv_pkg::*;

module muldiv_unit #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result_lo,
  output logic [WIDTH-1:0] result_hi,
  output logic             flag_n,
  output logic             flag_z
);

  localparam int CW = $clog2(WIDTH);

  muldiv_state_t      state, state_n;
  logic [2:0]         op_q;
  logic [WIDTH-1:0]   mcand;
  logic [WIDTH-1:0]   hi_q, lo_q;
  logic [WIDTH-1:0]   step_hi, step_lo;
  logic [CW-1:0]      cnt;
  logic               neg_q;
  logic               accept, div0, is_div, is_smul;
  logic [2*WIDTH-1:0] prod_fix;
  logic               fix_n, fix_z;

  assign accept  = start && op[2] && (state == S_IDLE || state == S_DONE);
  assign div0    = (op == OP_DIV) && (b == '0);
  assign is_div  = (op_q == OP_DIV);
  assign is_smul = (op == OP_SMUL);

  muldiv_step #(.WIDTH(WIDTH)) u_step (
    .is_div (is_div),
    .hi_in  (hi_q),
    .lo_in  (lo_q),
    .m      (mcand),
    .hi_out (step_hi),
    .lo_out (step_lo)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= S_IDLE;
    else       state <= state_n;
  end

  always_comb begin
    state_n = state;
    if (accept) begin
      state_n = div0 ? S_DONE : S_CALC;
    end else begin
      case (state)
        S_IDLE:  state_n = S_IDLE;
        S_CALC:  if (cnt == '0) state_n = S_FIX;
        S_FIX:   state_n = S_DONE;
        S_DONE:  state_n = S_IDLE;
        default: state_n = S_IDLE;
      endcase
    end
  end

  // Sign fix and flag selection applied on the FIX cycle
  always_comb begin
    prod_fix = neg_q ? -{hi_q, lo_q} : {hi_q, lo_q};
    fix_n    = prod_fix[2*WIDTH-1];
    fix_z    = (prod_fix == '0);
    if (op_q == OP_MUL || op_q == OP_DIV) begin
      fix_n = prod_fix[WIDTH-1];
      fix_z = (prod_fix[WIDTH-1:0] == '0);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      busy      <= 1'b0;
      done      <= 1'b0;
      result_lo <= '0;
      result_hi <= '0;
      flag_n    <= 1'b0;
      flag_z    <= 1'b0;
      op_q      <= '0;
      mcand     <= '0;
      hi_q      <= '0;
      lo_q      <= '0;
      cnt       <= '0;
      neg_q     <= 1'b0;
    end else begin
      busy <= (state_n == S_CALC) || (state_n == S_FIX);
      done <= (state_n == S_DONE);
      if (accept) begin
        op_q  <= op;
        hi_q  <= '0;
        cnt   <= CW'(WIDTH - 1);
        neg_q <= is_smul && (a[WIDTH-1] ^ b[WIDTH-1]);
        lo_q  <= (is_smul && a[WIDTH-1]) ? -a : a;
        mcand <= (is_smul && b[WIDTH-1]) ? -b : b;
        if (div0) begin
          result_lo <= '1;
          result_hi <= a;
          flag_n    <= 1'b1;
          flag_z    <= 1'b0;
        end
      end else if (state == S_CALC) begin
        hi_q <= step_hi;
        lo_q <= step_lo;
        cnt  <= cnt - CW'(1);
      end else if (state == S_FIX) begin
        result_lo <= prod_fix[WIDTH-1:0];
        result_hi <= prod_fix[2*WIDTH-1:WIDTH];
        flag_n    <= fix_n;
        flag_z    <= fix_z;
      end
    end
  end

endmodule

// File: tb/tb_muldiv_unit.sv
// tb/tb_muldiv_unit.sv - directed self-checking bench for muldiv_unit
module tb_muldiv_unit;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic [2:0]  op = 3'b000;
  logic [31:0] a = '0;
  logic [31:0] b = '0;
  logic        busy, done, flag_n, flag_z;
  logic [31:0] result_lo, result_hi;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  muldiv_unit #(.WIDTH(32)) dut (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .op        (op),
    .a         (a),
    .b         (b),
    .busy      (busy),
    .done      (done),
    .result_lo (result_lo),
    .result_hi (result_hi),
    .flag_n    (flag_n),
    .flag_z    (flag_z)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Called just after a clock edge; returns with the bench sitting in the done cycle.
  // inj > 0 pulses start with a different op in that cycle of the operation.
  task automatic do_op(input logic [2:0] o, input logic [31:0] x, input logic [31:0] y,
                       input int inj, output int lat, output int bcnt);
    op = o; a = x; b = y; start = 1'b1;
    lat = 0; bcnt = 0;
    for (int i = 0; i < 100; i++) begin
      @(posedge clk); #1;
      lat++;
      start = 1'b0;
      if (done) break;
      if (busy) bcnt++;
      if (lat == inj) begin
        start = 1'b1; op = 3'b110; a = 32'h0000_0055; b = 32'h0000_0033;
      end
    end
    if (!done) check("done_timeout", 64'(lat), 64'd0);
  endtask

  int lat, bcnt, seen;

  initial begin
    repeat (2) @(posedge clk);
    #1;
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_done", 64'(done), 64'd0);
    check("rst_lo",   64'(result_lo), 64'd0);
    check("rst_hi",   64'(result_hi), 64'd0);
    check("rst_nz",   64'({flag_n, flag_z}), 64'd0);
    reset = 1'b0;
    @(posedge clk); #1;

    // MUL 7*6 with a stray start in cycle 10
    do_op(3'b100, 32'd7, 32'd6, 10, lat, bcnt);
    check("mul_lat",  64'(lat), 64'd34);
    check("mul_busy", 64'(bcnt), 64'd33);
    check("mul_lo",   64'(result_lo), 64'd42);
    check("mul_nz",   64'({flag_n, flag_z}), 64'd0);

    // back-to-back accept in the DONE cycle
    do_op(3'b100, 32'd11, 32'd13, 0, lat, bcnt);
    check("b2b_lat", 64'(lat), 64'd34);
    check("b2b_lo",  64'(result_lo), 64'd143);

    do_op(3'b101, 32'hFFFF_FFFD, 32'd5, 0, lat, bcnt);
    check("smul_res", {result_hi, result_lo}, 64'hFFFF_FFFF_FFFF_FFF1);
    check("smul_nz",  64'({flag_n, flag_z}), 64'd2);

    do_op(3'b101, 32'h8000_0000, 32'd2, 0, lat, bcnt);
    check("smul_min", {result_hi, result_lo}, 64'hFFFF_FFFF_0000_0000);

    do_op(3'b110, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0, lat, bcnt);
    check("umul_max", {result_hi, result_lo}, 64'hFFFF_FFFE_0000_0001);
    check("umul_n",   64'(flag_n), 64'd1);

    do_op(3'b110, 32'd0, 32'd9, 0, lat, bcnt);
    check("umul_zero", {result_hi, result_lo}, 64'd0);
    check("umul_z",    64'(flag_z), 64'd1);

    do_op(3'b111, 32'd100, 32'd7, 0, lat, bcnt);
    check("div_lat", 64'(lat), 64'd34);
    check("div_res", {result_hi, result_lo}, {32'd2, 32'd14});
    check("div_nz",  64'({flag_n, flag_z}), 64'd0);

    do_op(3'b111, 32'd3, 32'd9, 0, lat, bcnt);
    check("div_small", {result_hi, result_lo}, {32'd3, 32'd0});
    check("div_z",     64'(flag_z), 64'd1);
    @(posedge clk); #1;
    check("done_pulse", 64'(done), 64'd0);

    do_op(3'b111, 32'd5, 32'd0, 0, lat, bcnt);
    check("div0_lat",  64'(lat), 64'd1);
    check("div0_busy", 64'(bcnt), 64'd0);
    check("div0_res",  {result_hi, result_lo}, {32'd5, 32'hFFFF_FFFF});
    check("div0_nz",   64'({flag_n, flag_z}), 64'd2);

    // reset in cycle 15 of a DIV
    @(posedge clk); #1;
    op = 3'b111; a = 32'd1000; b = 32'd7; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (14) begin @(posedge clk); #1; end
    check("pre_rst_busy", 64'(busy), 64'd1);
    reset = 1'b1;
    #1;
    check("mid_rst_busy", 64'(busy), 64'd0);
    check("mid_rst_done", 64'(done), 64'd0);
    check("mid_rst_res",  {result_hi, result_lo}, 64'd0);
    check("mid_rst_nz",   64'({flag_n, flag_z}), 64'd0);
    @(negedge clk);
    reset = 1'b0;
    @(posedge clk); #1;

    // invalid op is ignored
    seen = 0;
    op = 3'b010; a = 32'd4; b = 32'd4; start = 1'b1;
    repeat (5) begin
      @(posedge clk); #1;
      if (busy || done) seen++;
    end
    start = 1'b0;
    check("bad_op", 64'(seen), 64'd0);

    do_op(3'b100, 32'd3, 32'd4, 0, lat, bcnt);
    check("post_rst_lat", 64'(lat), 64'd34);
    check("post_rst_lo",  64'(result_lo), 64'd12);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/muldiv_unit.md
# muldiv_unit

Iterative multiply/divide execution unit for the multicycle core. It accepts the extended ALU operations MUL, SMUL, UMUL and DIV (ALUControl encodings 3'b100–3'b111) from the control path and performs them over multiple cycles. It returns a 64-bit result pair with N/Z flags and a one-cycle `done` pulse. The main FSM stalls while `busy` is high and writes `result_lo`, plus `result_hi` for long ops, on `done`.

## Interface
- `WIDTH`, 32: operand width. The iteration count equals `WIDTH`.
- `clk` in 1: single clock, rising edge.
- `reset` in 1: asynchronous, active-high.
- `start` in 1: request; sampled only in IDLE or DONE.
- `op` in 3: operation; 100 MUL, 101 SMUL, 110 UMUL, 111 DIV. Values 0xx are not valid.
- `a` in WIDTH: multiplicand or dividend; captured on accept.
- `b` in WIDTH: multiplier or divisor; captured on accept.
- `busy` out 1: operation in flight (CALC or FIX).
- `done` out 1: one-cycle pulse; results valid from this cycle.
- `result_lo` out WIDTH: low product word, or quotient.
- `result_hi` out WIDTH: high product word, or remainder.
- `flag_n` out 1: negative flag of the result.
- `flag_z` out 1: zero flag of the result.

## Operation
- States: IDLE, CALC, FIX, DONE.
- IDLE/DONE with `start`=1 and `op[2]`=1: accept. Latch `a`, `b`, `op`, clear the accumulators, load iteration counter = WIDTH-1, go to CALC.
- IDLE/DONE with `start`=1 and `op[2]`=0: ignored; the state does not change.
- DIV with `b`=0: skip CALC. Go to DONE on the next edge with `result_lo`=all ones and `result_hi`=`a`.
- CALC: one iteration per cycle. Leave after the counter reaches 0, i.e. after exactly WIDTH cycles. Then go to FIX.
  - MUL/UMUL: unsigned shift-add on the raw operands, 2·WIDTH-bit accumulator.
  - SMUL: shift-add on |a|, |b|. |0x80000000| is 0x80000000 treated as unsigned.
  - DIV: unsigned restoring division, one quotient bit per cycle. Remainder holds WIDTH+1 bits internally.
- FIX: one cycle. For SMUL with sign(a) ≠ sign(b), negate the 64-bit product (two's complement). Other ops pass through. Write the results into the output registers, then go to DONE.
- DONE: `done`=1 for this cycle only. Without a new accept, go to IDLE.
- `result_lo`, `result_hi` and the flags hold their values until the next FIX or div-by-zero DONE.
- MUL: `result_hi` holds the upper product bits; the core ignores it. Flags come from `result_lo` only.
- SMUL/UMUL: `flag_n` = `result_hi[WIDTH-1]`; `flag_z` = 64-bit result is zero.
- DIV: `flag_n` = `result_lo[WIDTH-1]`; `flag_z` = quotient is zero.
- `start` while `busy`: ignored. No queueing, no abort.
- Reset, at any time including mid-CALC: state goes to IDLE immediately. All outputs and internal registers are cleared; the operation in flight is discarded.

## Timing
- Reset values: `busy`=0, `done`=0, `result_lo`=0, `result_hi`=0, `flag_n`=0, `flag_z`=0.
- All outputs are registered; no combinational path from inputs to outputs.
- Cycle numbering: cycle 0 is the accept cycle (`start`=1 in IDLE/DONE).
  - Cycles 1..WIDTH: CALC, `busy`=1.
  - Cycle WIDTH+1: FIX, `busy`=1.
  - Cycle WIDTH+2: DONE, `done`=1, `busy`=0, results valid. This is cycle 34 for WIDTH=32.
- Div-by-zero: DONE in cycle 1.
- Back-to-back: `start` in a DONE cycle is accepted; CALC begins the next cycle and no idle cycle is inserted.

## Structure
- Shared package `muldiv_pkg`:
  - op localparams `OP_MUL`, `OP_SMUL`, `OP_UMUL`, `OP_DIV`, matching the decoder's ALUControl encoding.
  - state enum `muldiv_state_t`.
- One sub-module, `muldiv_step`: combinational single iteration, selected by op. Shift-add step for multiply, or trial-subtract/restore step for divide. The parent holds the FSM, counter, operand and accumulator registers, and the FIX negation.

## Test plan
- MUL a=7, b=6: `done` in cycle 34; `result_lo`=42, `flag_z`=0, `flag_n`=0. `busy` is high in cycles 1–33.
- SMUL a=0xFFFFFFFD (−3), b=5: `result_hi`=0xFFFFFFFF, `result_lo`=0xFFFFFFF1, `flag_n`=1. Also SMUL 0x80000000 × 2 gives hi=0xFFFFFFFF, lo=0x00000000.
- UMUL a=b=0xFFFFFFFF: `result_hi`=0xFFFFFFFE, `result_lo`=0x00000001. Then UMUL 0×9 gives `flag_z`=1.
- DIV 100/7 gives lo=14, hi=2 in cycle 34. DIV 5/0 gives lo=0xFFFFFFFF, hi=5, `done` in cycle 1. DIV 3/9 gives lo=0, hi=3, `flag_z`=1.
- `start` pulsed with a different op in cycle 10 of a MUL: ignored, and the original result is returned in cycle 34. Then `start` during DONE is accepted, with `done` again 34 cycles later. `op`=3'b010 with `start`=1 in IDLE: no `busy`, no `done`.
- Assert `reset` in cycle 15 of a DIV: `busy`, `done` and all results are 0 immediately. After release, a fresh MUL 3×4 yields 12 with normal latency.
